cpu_control_fsm: RTL and testbench

//  Multicycle control unit directly upstream of the ALU. Holds the IR and the PSR flag register, decodes the
//  16-bit baseline ISA, and drives the alucont/immediate/register-file/PC/memory controls. Latches the ALU PSR

---
 rtl/cpu_control_fsm_pkg.sv | 159 +++++++++++++++
 rtl/cpu_control_fsm_branch_cond_eval.sv | 40 ++++
 rtl/cpu_control_fsm.sv | 136 +++++++++++++
 tb/tb_cpu_control_fsm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_fsm_pkg.sv
// rtl/cpu_control_fsm_pkg.sv - ISA constants, state encoding and decoder for cpu_control_fsm (RANDOM_MOVRI_EN adds MOVR)
package cpu_isa_defs;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_MEM    = 4'b0100;
    localparam logic [3:0] OP_SHIFT  = 4'b1000;
    localparam logic [3:0] OP_BCOND  = 4'b1100;
    localparam logic [3:0] OP_LUI    = 4'b1111;

    localparam logic [3:0] EXT_AND   = 4'b0001;
    localparam logic [3:0] EXT_OR    = 4'b0010;
    localparam logic [3:0] EXT_XOR   = 4'b0011;
    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_SUB   = 4'b1001;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_MOV   = 4'b1101;
    localparam logic [3:0] EXT_MOVR  = 4'b1111;
    localparam logic [3:0] EXT_LSH   = 4'b0100;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_CMP   = 4'b0101;
    localparam logic [3:0] ALU_MOV   = 4'b0110;
    localparam logic [3:0] ALU_LSH   = 4'b0111;
    localparam logic [3:0] ALU_LSHI  = 4'b1000;
    localparam logic [3:0] ALU_MOVR  = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4,  COND_LS = 4'd5,  COND_GT = 4'd6,  COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8,  COND_FC = 4'd9,  COND_LO = 4'd10, COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12, COND_GE = 4'd13, COND_UC = 4'd14;

    localparam int PSR_C = 0;
    localparam int PSR_F = 1;
    localparam int PSR_L = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_LD_ADDR, S_LD_WB, S_ST, S_BR
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_CMP, CLS_LOAD, CLS_STOR, CLS_BCOND, CLS_JCOND, CLS_JAL, CLS_ILL
    } instr_class_t;

    typedef enum logic [1:0] {PSR_HOLD, PSR_CF, PSR_LZN} psr_upd_t;

    typedef struct packed {
        instr_class_t cls;
        psr_upd_t     psr_upd;
        logic [3:0]   alucont;
        logic         alu_src_imm;
        logic [15:0]  imm;
    } decode_t;

    // Shared ALU op table: R-type ext codes and I-type opcodes use the same values.
    function automatic logic alu_code(input logic [3:0] code, output logic [3:0] ac,
                                      output psr_upd_t upd, output logic is_cmp);
        logic ok;
        ok = 1'b1;
        ac = ALU_ADD;
        upd = PSR_HOLD;
        is_cmp = 1'b0;
        case (code)
            EXT_AND: ac = ALU_AND;
            EXT_OR:  ac = ALU_OR;
            EXT_XOR: ac = ALU_XOR;
            EXT_ADD: begin ac = ALU_ADD; upd = PSR_CF; end
            EXT_SUB: begin ac = ALU_SUB; upd = PSR_CF; end
            EXT_CMP: begin ac = ALU_CMP; upd = PSR_LZN; is_cmp = 1'b1; end
            EXT_MOV: ac = ALU_MOV;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Decode from opcode and low byte; register fields are not needed to classify.
    function automatic decode_t decode_instr(input logic [3:0] op, input logic [7:0] lo);
        decode_t    d;
        logic       ok;
        logic [3:0] ac;
        psr_upd_t   upd;
        logic       is_cmp;
        d.cls         = CLS_ILL;
        d.psr_upd     = PSR_HOLD;
        d.alucont     = ALU_ADD;
        d.alu_src_imm = 1'b0;
        d.imm         = 16'h0000;
        case (op)
            OP_RTYPE: begin
                ok = alu_code(lo[7:4], ac, upd, is_cmp);
                if (ok) begin
                    d.cls     = is_cmp ? CLS_CMP : CLS_ALU;
                    d.alucont = ac;
                    d.psr_upd = upd;
                end
`ifdef RANDOM_MOVRI_EN
                else if (lo[7:4] == EXT_MOVR) begin
                    d.cls     = CLS_ALU;
                    d.alucont = ALU_MOVR;
                end
`endif
            end
            OP_SHIFT: begin
                if (lo[7:4] == EXT_LSH) begin
                    d.cls     = CLS_ALU;
                    d.alucont = ALU_LSH;
                end else if (lo[7:5] == 3'b000) begin
                    d.cls         = CLS_ALU;
                    d.alucont     = ALU_LSHI;
                    d.alu_src_imm = 1'b1;
                    d.imm         = {11'b0, lo[4:0]};
                end
            end
            OP_LUI: begin
                d.cls         = CLS_ALU;
                d.alucont     = ALU_MOV;
                d.alu_src_imm = 1'b1;
                d.imm         = {lo, 8'h00};
            end
            OP_MEM: begin
                case (lo[7:4])
                    EXT_LOAD:  d.cls = CLS_LOAD;
                    EXT_STOR:  d.cls = CLS_STOR;
                    EXT_JCOND: d.cls = CLS_JCOND;
                    EXT_JAL:   d.cls = CLS_JAL;
                    default:   d.cls = CLS_ILL;
                endcase
            end
            OP_BCOND: begin
                d.cls = CLS_BCOND;
                d.imm = {{8{lo[7]}}, lo};
            end
            default: begin
                ok = alu_code(op, ac, upd, is_cmp);
                if (ok) begin
                    d.cls         = is_cmp ? CLS_CMP : CLS_ALU;
                    d.alucont     = ac;
                    d.psr_upd     = upd;
                    d.alu_src_imm = 1'b1;
                    if (ac == ALU_ADD || ac == ALU_SUB || ac == ALU_CMP)
                        d.imm = {{8{lo[7]}}, lo};
                    else
                        d.imm = {8'h00, lo};
                end
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpu_control_fsm_branch_cond_eval.sv
// rtl/cpu_control_fsm_branch_cond_eval.sv - combinational branch condition evaluator
module branch_cond_eval
    import cpu_isa_defs::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] psr,
    output logic       taken
);

    logic c, f, l, z, n;
    assign c = psr[PSR_C];
    assign f = psr[PSR_F];
    assign l = psr[PSR_L];
    assign z = psr[PSR_Z];
    assign n = psr[PSR_N];

    // Map the 4-bit condition code onto the flag expression; code 15 never branches.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_HI: taken = l;
            COND_LS: taken = !l;
            COND_GT: taken = n;
            COND_LE: taken = !n;
            COND_FS: taken = f;
            COND_FC: taken = !f;
            COND_LO: taken = !l && !z;
            COND_HS: taken = l || z;
            COND_LT: taken = !n && !z;
            COND_GE: taken = n || z;
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multicycle control unit: IR/PSR, decode, datapath strobes
module cpu_control_fsm
    import cpu_isa_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [4:0]       alu_psr,
    output logic [3:0]       alucont,
    output logic             alu_src_imm,
    output logic [WIDTH-1:0] imm,
    output logic [3:0]       rdest_addr,
    output logic [3:0]       rsrc_addr,
    output logic             rf_we,
    output logic [1:0]       rf_wsel,
    output logic             mem_addr_sel,
    output logic             mem_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic [4:0]       psr_q,
    output logic             illegal
);

    state_t     state, state_nxt;
    logic [WIDTH-1:0] ir;
    decode_t    dec_ir;
    decode_t    dec_mem;
    logic       taken;

    assign dec_ir  = decode_instr(ir[15:12], ir[7:0]);
    assign dec_mem = decode_instr(mem_rdata[15:12], mem_rdata[7:0]);

    assign alucont     = dec_ir.alucont;
    assign alu_src_imm = dec_ir.alu_src_imm;
    assign imm         = dec_ir.imm;
    assign rdest_addr  = ir[11:8];
    assign rsrc_addr   = ir[3:0];

    branch_cond_eval u_cond (
        .cond  (ir[11:8]),
        .psr   (psr_q),
        .taken (taken)
    );

    // State, instruction register, flag latch and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_FETCH;
            ir      <= '0;
            psr_q   <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                ir <= mem_rdata;
            if (state == S_EXEC) begin
                case (dec_ir.psr_upd)
                    PSR_CF: begin
                        psr_q[PSR_C] <= alu_psr[PSR_C];
                        psr_q[PSR_F] <= alu_psr[PSR_F];
                    end
                    PSR_LZN: begin
                        psr_q[PSR_L] <= alu_psr[PSR_L];
                        psr_q[PSR_Z] <= alu_psr[PSR_Z];
                        psr_q[PSR_N] <= alu_psr[PSR_N];
                    end
                    default: ;
                endcase
                if (dec_ir.cls == CLS_ILL)
                    illegal <= 1'b1;
            end
        end
    end

    // Next state and per-state strobes; strobes are forced off while reset is asserted.
    always_comb begin
        state_nxt    = S_FETCH;
        rf_we        = 1'b0;
        rf_wsel      = 2'b00;
        mem_addr_sel = 1'b0;
        mem_we       = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 2'b00;
        case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (dec_mem.cls)
                    CLS_LOAD:                      state_nxt = S_LD_ADDR;
                    CLS_STOR:                      state_nxt = S_ST;
                    CLS_BCOND, CLS_JCOND, CLS_JAL: state_nxt = S_BR;
                    default:                       state_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                rf_we = (dec_ir.cls == CLS_ALU);
                pc_en = 1'b1;
            end
            S_LD_ADDR: begin
                mem_addr_sel = 1'b1;
                state_nxt    = S_LD_WB;
            end
            S_LD_WB: begin
                rf_we   = 1'b1;
                rf_wsel = 2'b01;
                pc_en   = 1'b1;
            end
            S_ST: begin
                mem_addr_sel = 1'b1;
                mem_we       = 1'b1;
                pc_en        = 1'b1;
            end
            S_BR: begin
                pc_en = 1'b1;
                case (dec_ir.cls)
                    CLS_BCOND: pc_sel = taken ? 2'b01 : 2'b00;
                    CLS_JCOND: pc_sel = taken ? 2'b10 : 2'b00;
                    CLS_JAL: begin
                        rf_we   = 1'b1;
                        rf_wsel = 2'b10;
                        pc_sel  = 2'b10;
                    end
                    default: pc_sel = 2'b00;
                endcase
            end
            default: state_nxt = S_FETCH;
        endcase
        if (!reset) begin
            rf_we  = 1'b0;
            mem_we = 1'b0;
            pc_en  = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - directed self-checking bench for cpu_control_fsm
module tb_cpu_control_fsm;

    logic        clk;
    logic        reset;
    logic [15:0] mem_rdata;
    logic [4:0]  alu_psr;
    logic [3:0]  alucont;
    logic        alu_src_imm;
    logic [15:0] imm;
    logic [3:0]  rdest_addr;
    logic [3:0]  rsrc_addr;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic        mem_addr_sel;
    logic        mem_we;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [4:0]  psr_q;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic rec_rf_we   [8];
    logic rec_pc_en   [8];
    logic rec_mem_we  [8];
    logic rec_addr_sel[8];
    int   n_pc, n_rf, n_mem;

    cpu_control_fsm #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_rdata    (mem_rdata),
        .alu_psr      (alu_psr),
        .alucont      (alucont),
        .alu_src_imm  (alu_src_imm),
        .imm          (imm),
        .rdest_addr   (rdest_addr),
        .rsrc_addr    (rsrc_addr),
        .rf_we        (rf_we),
        .rf_wsel      (rf_wsel),
        .mem_addr_sel (mem_addr_sel),
        .mem_we       (mem_we),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .psr_q        (psr_q),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start in FETCH; run ncyc states, leaving the DUT sampled in the final state.
    task automatic exec_instr(input logic [15:0] instr, input int ncyc);
        mem_rdata = instr;
        n_pc = 0;
        n_rf = 0;
        n_mem = 0;
        for (int i = 0; i < ncyc; i++) begin
            rec_rf_we[i]    = rf_we;
            rec_pc_en[i]    = pc_en;
            rec_mem_we[i]   = mem_we;
            rec_addr_sel[i] = mem_addr_sel;
            n_pc  += int'(pc_en);
            n_rf  += int'(rf_we);
            n_mem += int'(mem_we);
            if (i < ncyc - 1)
                step();
        end
    endtask

    initial begin
        reset     = 1'b0;
        mem_rdata = 16'h0000;
        alu_psr   = 5'b00000;
        step();
        step();
        reset = 1'b1;
        #1;
        check_eq("rst_psr_q",    32'(psr_q), 32'h0);
        check_eq("rst_illegal",  32'(illegal), 32'h0);
        check_eq("rst_alucont",  32'(alucont), 32'h0);
        check_eq("rst_strobes",  32'({rf_we, mem_we, pc_en}), 32'h0);
        check_eq("rst_addr_sel", 32'(mem_addr_sel), 32'h0);

        // ADDI R3,#-1
        alu_psr = 5'b00001;
        exec_instr(16'h53FF, 3);
        check_eq("addi_imm",     32'(imm), 32'hFFFF);
        check_eq("addi_alucont", 32'(alucont), 32'h0);
        check_eq("addi_srcimm",  32'(alu_src_imm), 32'h1);
        check_eq("addi_rf_we3",  32'(rec_rf_we[2]), 32'h1);
        check_eq("addi_rf_early", 32'(rec_rf_we[0] | rec_rf_we[1]), 32'h0);
        check_eq("addi_rdest",   32'(rdest_addr), 32'h3);
        check_eq("addi_pc_once", 32'(n_pc), 32'd1);
        step();
        check_eq("addi_psr_q",   32'(psr_q), 32'h01);

        // CMP R1,R2 loads L,Z,N only
        alu_psr = 5'b01000;
        exec_instr(16'h01B2, 3);
        check_eq("cmp_rf_we",    32'(n_rf), 32'd0);
        check_eq("cmp_alucont",  32'(alucont), 32'h5);
        step();
        check_eq("cmp_psr_q",    32'(psr_q), 32'h09);

        // BEQ +4 taken on Z=1
        exec_instr(16'hC004, 3);
        check_eq("beq_pc_sel",   32'(pc_sel), 32'h1);
        check_eq("beq_imm",      32'(imm), 32'h0004);
        check_eq("beq_rf_we",    32'(n_rf), 32'd0);
        check_eq("beq_pc_once",  32'(n_pc), 32'd1);
        step();

        // BNE not taken on Z=1
        exec_instr(16'hC104, 3);
        check_eq("bne_pc_sel",   32'(pc_sel), 32'h0);
        check_eq("bne_pc_en",    32'(pc_en), 32'h1);
        step();

        // BLO not taken (Z=1), BCS taken (C=1), Jcond UC via Rsrc
        exec_instr(16'hCAFE, 3);
        check_eq("blo_pc_sel",   32'(pc_sel), 32'h0);
        check_eq("blo_imm",      32'(imm), 32'hFFFE);
        step();
        exec_instr(16'hC210, 3);
        check_eq("bcs_pc_sel",   32'(pc_sel), 32'h1);
        step();
        exec_instr(16'h4EC3, 3);
        check_eq("juc_pc_sel",   32'(pc_sel), 32'h2);
        check_eq("juc_rf_we",    32'(rf_we), 32'h0);
        step();

        // JAL R14,R5
        exec_instr(16'h4E85, 3);
        check_eq("jal_rf_we",    32'(rf_we), 32'h1);
        check_eq("jal_wsel",     32'(rf_wsel), 32'h2);
        check_eq("jal_pc_sel",   32'(pc_sel), 32'h2);
        check_eq("jal_regs",     32'({rdest_addr, rsrc_addr}), 32'hE5);
        step();

        // LOAD R2,[R7]
        exec_instr(16'h4207, 4);
        check_eq("ld_addr_sel",  32'(rec_addr_sel[2]), 32'h1);
        check_eq("ld_addr_quiet", 32'({rec_rf_we[2], rec_pc_en[2]}), 32'h0);
        check_eq("ld_wb_rf_we",  32'(rf_we), 32'h1);
        check_eq("ld_wb_wsel",   32'(rf_wsel), 32'h1);
        check_eq("ld_pc_once",   32'(n_pc), 32'd1);
        check_eq("ld_pc_last",   32'(rec_pc_en[3]), 32'h1);
        step();

        // STOR
        exec_instr(16'h4247, 3);
        check_eq("st_mem_we",    32'(mem_we), 32'h1);
        check_eq("st_addr_sel",  32'(mem_addr_sel), 32'h1);
        check_eq("st_mem_once",  32'(n_mem), 32'd1);
        check_eq("st_rf_we",     32'(n_rf), 32'd0);
        step();

        // ANDI zero-extends, holds PSR
        alu_psr = 5'b11111;
        exec_instr(16'h1380, 3);
        check_eq("andi_imm",     32'(imm), 32'h0080);
        check_eq("andi_alucont", 32'(alucont), 32'h2);
        step();
        check_eq("andi_psr_hold", 32'(psr_q), 32'h09);

        // LUI and LSHI immediates
        exec_instr(16'hF2AB, 3);
        check_eq("lui_imm",      32'(imm), 32'hAB00);
        check_eq("lui_alucont",  32'({alu_src_imm, alucont}), 32'h16);
        step();
        exec_instr(16'h8315, 3);
        check_eq("lshi_imm",     32'(imm), 32'h0015);
        check_eq("lshi_alucont", 32'(alucont), 32'h8);
        step();

        // 0x00F3: MOVR or illegal
        exec_instr(16'h00F3, 3);
`ifdef RANDOM_MOVRI_EN
        check_eq("movr_alucont", 32'(alucont), 32'hA);
        check_eq("movr_rf_we",   32'(rf_we), 32'h1);
        step();
        check_eq("movr_legal",   32'(illegal), 32'h0);
`else
        check_eq("ill_writes",   32'(n_rf + n_mem), 32'd0);
        check_eq("ill_pc_sel",   32'(pc_sel), 32'h0);
        check_eq("ill_pc_en",    32'(pc_en), 32'h1);
        step();
        check_eq("ill_flag",     32'(illegal), 32'h1);
        check_eq("ill_psr_hold", 32'(psr_q), 32'h09);
        exec_instr(16'h1380, 3);
        step();
        check_eq("ill_sticky",   32'(illegal), 32'h1);
`endif

        // Reset asserted during LOAD write-back
        mem_rdata = 16'h4207;
        step();
        step();
        check_eq("rst_ld_addr",  32'(mem_addr_sel), 32'h1);
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_ld_abort", 32'({rf_we, mem_we, pc_en}), 32'h0);
        step();
        step();
        reset = 1'b1;
        #1;
        check_eq("rst2_psr_q",   32'(psr_q), 32'h0);
        check_eq("rst2_illegal", 32'(illegal), 32'h0);
        check_eq("rst2_fetch",   32'({mem_addr_sel, pc_en, rf_we}), 32'h0);
        alu_psr = 5'b00000;
        exec_instr(16'h53FF, 3);
        check_eq("rst2_realign", 32'({rec_rf_we[1], rec_rf_we[2]}), 32'h1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
